// File: rtl/ifu_fetch.sv
// ifu_fetch: multi-cycle instruction fetch stage with a registered request/response bus.
// The optional WAIT-state timeout is enabled by defining IFU_TIMEOUT_EN.
module ifu_fetch #(
    parameter int unsigned     XLEN           = 32,
    parameter logic [XLEN-1:0] PC_RST_VEC     = 32'h80000000,
    parameter int unsigned     TIMEOUT_CYCLES = 255
) (
    input  logic            clk,
    input  logic            rst_b,
    input  logic            pc_branch,
    input  logic [XLEN-1:0] target_pc,
    input  logic            trap,
    input  logic [XLEN-1:0] trap_pc,
    output logic            ibus_req_valid,
    input  logic            ibus_req_ready,
    output logic [XLEN-1:0] ibus_req_addr,
    input  logic            ibus_rsp_valid,
    input  logic [XLEN-1:0] ibus_rsp_data,
    input  logic            ibus_rsp_err,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] inst_pc,
    output logic            inst_err
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD} state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] inst_q, inst_d;
    logic [XLEN-1:0] inst_pc_q, inst_pc_d;
    logic            inst_err_q, inst_err_d;

    if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be nonzero");
    end

`ifdef IFU_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt_q, cnt_d;
`endif

    assign ibus_req_valid = (state_q == S_REQ) && (pc_q[1:0] == 2'b00);
    assign ibus_req_addr  = pc_q;
    assign inst_valid     = (state_q == S_HOLD);
    assign inst           = inst_q;
    assign inst_pc        = inst_pc_q;
    assign inst_err       = inst_err_q;

    // Next-state, next-PC and captured-instruction logic
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        inst_d     = inst_q;
        inst_pc_d  = inst_pc_q;
        inst_err_d = inst_err_q;
`ifdef IFU_TIMEOUT_EN
        cnt_d      = cnt_q;
`endif
        case (state_q)
            S_IDLE: state_d = S_REQ;
            S_REQ: begin
                if (pc_q[1:0] != 2'b00) begin
                    state_d    = S_HOLD;
                    inst_d     = '0;
                    inst_err_d = 1'b1;
                    inst_pc_d  = pc_q;
                end else if (ibus_req_ready) begin
                    state_d = S_WAIT;
`ifdef IFU_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            S_WAIT: begin
                if (ibus_rsp_valid) begin
                    state_d    = S_HOLD;
                    inst_d     = ibus_rsp_err ? '0 : ibus_rsp_data;
                    inst_err_d = ibus_rsp_err;
                    inst_pc_d  = pc_q;
                end
`ifdef IFU_TIMEOUT_EN
                else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                    state_d    = S_HOLD;
                    inst_d     = '0;
                    inst_err_d = 1'b1;
                    inst_pc_d  = pc_q;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
`endif
            end
            S_HOLD: begin
                if (inst_ready) begin
                    state_d = S_REQ;
                    pc_d    = trap ? trap_pc : pc_branch ? target_pc : pc_q + XLEN'(4);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers with asynchronous reset
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q    <= S_IDLE;
            pc_q       <= PC_RST_VEC;
            inst_q     <= '0;
            inst_pc_q  <= PC_RST_VEC;
            inst_err_q <= 1'b0;
`ifdef IFU_TIMEOUT_EN
            cnt_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            inst_q     <= inst_d;
            inst_pc_q  <= inst_pc_d;
            inst_err_q <= inst_err_d;
`ifdef IFU_TIMEOUT_EN
            cnt_q      <= cnt_d;
`endif
        end
    end

`ifndef SYNTHESIS
    a_rsp_only_in_wait: assert property (@(posedge clk) disable iff (!rst_b)
        ibus_rsp_valid |-> state_q == S_WAIT)
        else $error("ibus_rsp_valid outside WAIT");
`endif

endmodule

// File: tb/tb_ifu_fetch.sv
// tb_ifu_fetch: directed self-checking bench for ifu_fetch.
module tb_ifu_fetch;

    logic        clk = 1'b0;
    logic        rst_b;
    logic        pc_branch;
    logic [31:0] target_pc;
    logic        trap;
    logic [31:0] trap_pc;
    logic        ibus_req_valid;
    logic        ibus_req_ready;
    logic [31:0] ibus_req_addr;
    logic        ibus_rsp_valid;
    logic [31:0] ibus_rsp_data;
    logic        ibus_rsp_err;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_err;

    int n_cmp = 0;
    int n_bad = 0;

    ifu_fetch #(
        .XLEN(32),
        .PC_RST_VEC(32'h80000000),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk(clk),
        .rst_b(rst_b),
        .pc_branch(pc_branch),
        .target_pc(target_pc),
        .trap(trap),
        .trap_pc(trap_pc),
        .ibus_req_valid(ibus_req_valid),
        .ibus_req_ready(ibus_req_ready),
        .ibus_req_addr(ibus_req_addr),
        .ibus_rsp_valid(ibus_rsp_valid),
        .ibus_rsp_data(ibus_rsp_data),
        .ibus_rsp_err(ibus_rsp_err),
        .inst_valid(inst_valid),
        .inst_ready(inst_ready),
        .inst(inst),
        .inst_pc(inst_pc),
        .inst_err(inst_err)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    // Starts in REQ at a word-aligned address, completes a zero-wait fetch, ends in HOLD
    task automatic do_fetch(input logic [31:0] addr, input logic [31:0] data, input logic err,
                            input logic [31:0] exp_inst, input logic exp_err);
        chk("req_valid", {31'b0, ibus_req_valid}, 32'd1);
        chk("req_addr", ibus_req_addr, addr);
        ibus_req_ready = 1'b1;
        tick();
        ibus_req_ready = 1'b0;
        chk("wait_req_valid", {31'b0, ibus_req_valid}, 32'd0);
        chk("wait_inst_valid", {31'b0, inst_valid}, 32'd0);
        ibus_rsp_valid = 1'b1;
        ibus_rsp_data  = data;
        ibus_rsp_err   = err;
        tick();
        ibus_rsp_valid = 1'b0;
        ibus_rsp_err   = 1'b0;
        chk("hold_inst_valid", {31'b0, inst_valid}, 32'd1);
        chk("hold_inst", inst, exp_inst);
        chk("hold_inst_err", {31'b0, inst_err}, {31'b0, exp_err});
        chk("hold_inst_pc", inst_pc, addr);
    endtask

    initial begin
        rst_b          = 1'b0;
        pc_branch      = 1'b0;
        target_pc      = '0;
        trap           = 1'b0;
        trap_pc        = '0;
        ibus_req_ready = 1'b0;
        ibus_rsp_valid = 1'b0;
        ibus_rsp_data  = '0;
        ibus_rsp_err   = 1'b0;
        inst_ready     = 1'b0;
        tick();
        tick();
        chk("rst_req_valid", {31'b0, ibus_req_valid}, 32'd0);
        chk("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
        chk("rst_inst", inst, 32'h0);
        chk("rst_inst_err", {31'b0, inst_err}, 32'd0);
        chk("rst_inst_pc", inst_pc, 32'h80000000);
        chk("rst_req_addr", ibus_req_addr, 32'h80000000);
        rst_b = 1'b1;
        chk("idle_req_valid", {31'b0, ibus_req_valid}, 32'd0);
        tick();

        // Back-to-back zero-wait fetches with decode always ready
        inst_ready = 1'b1;
        do_fetch(32'h80000000, 32'h00000013, 1'b0, 32'h00000013, 1'b0);
        tick();
        do_fetch(32'h80000004, 32'h00000013, 1'b0, 32'h00000013, 1'b0);
        tick();
        do_fetch(32'h80000008, 32'h00000013, 1'b0, 32'h00000013, 1'b0);
        tick();

        // Bus stalls the request for 4 cycles; decode stalls the instruction
        inst_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("stall_req_valid", {31'b0, ibus_req_valid}, 32'd1);
            chk("stall_req_addr", ibus_req_addr, 32'h8000000C);
            tick();
        end
        do_fetch(32'h8000000C, 32'h00500113, 1'b0, 32'h00500113, 1'b0);
        pc_branch = 1'b1;
        target_pc = 32'h80000300;
        tick();
        tick();
        chk("dstall_inst_valid", {31'b0, inst_valid}, 32'd1);
        chk("dstall_inst", inst, 32'h00500113);
        chk("dstall_req_valid", {31'b0, ibus_req_valid}, 32'd0);

        // Trap wins over branch
        inst_ready = 1'b1;
        pc_branch  = 1'b1;
        target_pc  = 32'h80000100;
        trap       = 1'b1;
        trap_pc    = 32'h80000200;
        tick();
        inst_ready = 1'b0;
        pc_branch  = 1'b0;
        trap       = 1'b0;
        chk("trap_addr", ibus_req_addr, 32'h80000200);
        do_fetch(32'h80000200, 32'h00100093, 1'b0, 32'h00100093, 1'b0);
        inst_ready = 1'b1;
        pc_branch  = 1'b1;
        target_pc  = 32'h80000100;
        tick();
        inst_ready = 1'b0;
        pc_branch  = 1'b0;
        chk("branch_addr", ibus_req_addr, 32'h80000100);

        // Branch to a misaligned target faults without a bus request
        do_fetch(32'h80000100, 32'h00000013, 1'b0, 32'h00000013, 1'b0);
        inst_ready = 1'b1;
        pc_branch  = 1'b1;
        target_pc  = 32'h80000102;
        tick();
        inst_ready = 1'b0;
        pc_branch  = 1'b0;
        chk("mis_req_valid", {31'b0, ibus_req_valid}, 32'd0);
        tick();
        chk("mis_req_valid2", {31'b0, ibus_req_valid}, 32'd0);
        chk("mis_inst_valid", {31'b0, inst_valid}, 32'd1);
        chk("mis_inst_err", {31'b0, inst_err}, 32'd1);
        chk("mis_inst", inst, 32'h0);
        chk("mis_inst_pc", inst_pc, 32'h80000102);
        inst_ready = 1'b1;
        pc_branch  = 1'b1;
        target_pc  = 32'h80000104;
        tick();
        inst_ready = 1'b0;
        pc_branch  = 1'b0;

        // Bus error response
        do_fetch(32'h80000104, 32'hDEADBEEF, 1'b1, 32'h0, 1'b1);
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        do_fetch(32'h80000108, 32'h00000013, 1'b0, 32'h00000013, 1'b0);
        inst_ready = 1'b1;
        tick();
        inst_ready     = 1'b0;
        ibus_req_ready = 1'b1;
        tick();
        ibus_req_ready = 1'b0;

        // Asynchronous reset while in WAIT
        rst_b = 1'b0;
        #1;
        chk("arst_req_valid", {31'b0, ibus_req_valid}, 32'd0);
        chk("arst_inst_valid", {31'b0, inst_valid}, 32'd0);
        chk("arst_inst", inst, 32'h0);
        chk("arst_inst_pc", inst_pc, 32'h80000000);
        chk("arst_req_addr", ibus_req_addr, 32'h80000000);
        tick();
        rst_b = 1'b1;
        tick();
        do_fetch(32'h80000000, 32'h00000013, 1'b0, 32'h00000013, 1'b0);

`ifdef IFU_TIMEOUT_EN
        // No response: fault after 8 WAIT cycles
        inst_ready = 1'b1;
        tick();
        inst_ready     = 1'b0;
        ibus_req_ready = 1'b1;
        tick();
        ibus_req_ready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            tick();
            chk("to_wait_inst_valid", {31'b0, inst_valid}, 32'd0);
        end
        tick();
        chk("to_inst_valid", {31'b0, inst_valid}, 32'd1);
        chk("to_inst_err", {31'b0, inst_err}, 32'd1);
        chk("to_inst", inst, 32'h0);
        chk("to_inst_pc", inst_pc, 32'h80000004);
        // Response on the limit cycle wins
        inst_ready = 1'b1;
        tick();
        inst_ready     = 1'b0;
        ibus_req_ready = 1'b1;
        tick();
        ibus_req_ready = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        chk("late_inst_valid", {31'b0, inst_valid}, 32'd0);
        ibus_rsp_valid = 1'b1;
        ibus_rsp_data  = 32'h00000013;
        tick();
        ibus_rsp_valid = 1'b0;
        chk("late_inst_valid2", {31'b0, inst_valid}, 32'd1);
        chk("late_inst_err", {31'b0, inst_err}, 32'd0);
        chk("late_inst", inst, 32'h00000013);
        chk("late_inst_pc", inst_pc, 32'h80000008);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
